// File: rtl/fifo_rr_merge.sv
// Two-source round-robin merge with burst limit, feeding a 2-entry skid buffer.
// Each buffered entry carries its source index; per-source accept counters wrap.
module fifo_rr_merge #(
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] data_in0,
    input  logic        data_in_vld0,
    output logic        data_in_rdy0,
    input  logic [15:0] data_in1,
    input  logic        data_in_vld1,
    output logic        data_in_rdy1,
    output logic [15:0] data_out,
    output logic        data_out_src,
    output logic        data_out_vld,
    input  logic        data_out_rdy,
    output logic [15:0] acc_cnt0,
    output logic [15:0] acc_cnt1
);

    localparam logic [3:0] LP_MAX = 4'(MAX_BURST);

    logic [16:0] r_head;
    logic [16:0] r_tail;
    logic [1:0]  r_occ;
    logic        r_ptr;
    logic [3:0]  r_bc;
    logic [15:0] r_cnt0;
    logic [15:0] r_cnt1;

    logic        w_can;
    logic        w_rdy0;
    logic        w_rdy1;
    logic        w_acc0;
    logic        w_acc1;
    logic        w_push;
    logic        w_pop;
    logic [16:0] w_din;
    logic [3:0]  w_bc_inc;
    logic        w_ptr_nxt;
    logic [3:0]  w_bc_nxt;

    // Readiness uses only registered occupancy, never the downstream ready.
    assign w_can  = rst_n && (r_occ != 2'd2);
    assign w_rdy0 = w_can && (!r_ptr || !data_in_vld1);
    assign w_rdy1 = w_can && (r_ptr || !data_in_vld0);
    assign w_acc0 = data_in_vld0 && w_rdy0;
    assign w_acc1 = data_in_vld1 && w_rdy1;
    assign w_push = w_acc0 || w_acc1;
    assign w_pop  = (r_occ != 2'd0) && data_out_rdy;
    assign w_din  = w_acc1 ? {1'b1, data_in1} : {1'b0, data_in0};

    always_comb begin
        w_bc_inc  = (w_acc1 != r_ptr) ? 4'd1 : r_bc + 4'd1;
        w_ptr_nxt = w_acc1;
        w_bc_nxt  = w_bc_inc;
        if (w_bc_inc == LP_MAX) begin
            w_ptr_nxt = ~w_acc1;
            w_bc_nxt  = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= 2'd0;
            r_ptr  <= 1'b0;
            r_bc   <= 4'd0;
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_push) begin
                r_ptr <= w_ptr_nxt;
                r_bc  <= w_bc_nxt;
            end
            if (w_acc0) r_cnt0 <= r_cnt0 + 16'd1;
            if (w_acc1) r_cnt1 <= r_cnt1 + 16'd1;
            // Head register keeps its value when the buffer drains empty.
            case (r_occ)
                2'd0: begin
                    if (w_push) begin
                        r_head <= w_din;
                        r_occ  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (w_push && w_pop) begin
                        r_head <= w_din;
                    end else if (w_push) begin
                        r_tail <= w_din;
                        r_occ  <= 2'd2;
                    end else if (w_pop) begin
                        r_occ  <= 2'd0;
                    end
                end
                default: begin
                    if (w_pop) begin
                        r_head <= r_tail;
                        r_occ  <= 2'd1;
                    end
                end
            endcase
        end
    end

    assign data_in_rdy0 = w_rdy0;
    assign data_in_rdy1 = w_rdy1;
    assign data_out     = r_head[15:0];
    assign data_out_src = r_head[16];
    assign data_out_vld = (r_occ != 2'd0);
    assign acc_cnt0     = r_cnt0;
    assign acc_cnt1     = r_cnt1;

endmodule
